universal_shift_reg: RTL

- Parametrised universal shift register. Successor to the fixed 4-bit serial-in shift register.
- Adds width `WIDTH`, bidirectional shift, rotate and parallel load, with serial outputs at both ends.
- Adds a frame counter that pulses when `WIDTH` shift/rotate operations have completed since the last load or reset.
- Serves the serial-link and SPI-style front ends as their SIPO/PISO stage.

---
 rtl/universal_shift_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: shift/rotate in both directions plus parallel load.
// A frame counter raises frame_done when WIDTH shift/rotate ops have landed since the last load or reset.
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift_en,
  input  logic [2:0]                 mode,
  input  logic                       ser_in_lsb,
  input  logic                       ser_in_msb,
  input  logic [WIDTH-1:0]           par_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       ser_out_msb,
  output logic                       ser_out_lsb,
  output logic [$clog2(WIDTH)-1:0]   shift_cnt,
  output logic                       frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  logic [WIDTH-1:0] next_data_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic             next_done_s;
  logic             is_shift_s;
  logic             is_load_s;

  // Operation decode and next data value
  always_comb begin
    next_data_s = data_out;
    is_shift_s  = 1'b0;
    is_load_s   = 1'b0;
    if (shift_en) begin
      case (mode)
        MODE_SHL: begin
          next_data_s = {data_out[WIDTH-2:0], ser_in_lsb};
          is_shift_s  = 1'b1;
        end
        MODE_SHR: begin
          next_data_s = {ser_in_msb, data_out[WIDTH-1:1]};
          is_shift_s  = 1'b1;
        end
        MODE_ROL: begin
          next_data_s = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
          is_shift_s  = 1'b1;
        end
        MODE_ROR: begin
          next_data_s = {data_out[0], data_out[WIDTH-1:1]};
          is_shift_s  = 1'b1;
        end
        MODE_LOAD: begin
          next_data_s = par_in;
          is_load_s   = 1'b1;
        end
        default: begin
          next_data_s = data_out;
        end
      endcase
    end else begin
      next_data_s = data_out;
    end
  end

  // Frame counter: wrap and pulse on the op that completes WIDTH shifts
  always_comb begin
    next_cnt_s  = shift_cnt;
    next_done_s = 1'b0;
    if (is_load_s) begin
      next_cnt_s = '0;
    end else if (is_shift_s) begin
      if (shift_cnt == CNT_LAST) begin
        next_cnt_s  = '0;
        next_done_s = 1'b1;
      end else begin
        next_cnt_s = shift_cnt + CNT_W'(1);
      end
    end else begin
      next_cnt_s = shift_cnt;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= RESET_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      data_out   <= next_data_s;
      shift_cnt  <= next_cnt_s;
      frame_done <= next_done_s;
    end
  end

  assign ser_out_msb = data_out[WIDTH-1];
  assign ser_out_lsb = data_out[0];

endmodule
